// File: rtl/exponent_align.sv
// exponent_align: input-side operand alignment for the FP adder datapath.
//
// Unpacks two IEEE-754 single-precision operands and picks the one with the
// larger magnitude. The smaller operand's mantissa is then shifted right by
// the exponent difference, one bit per cycle, while guard/round/sticky bits
// are kept. The aligned pair goes to the mantissa adder over valid/ready.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b sampled on acceptance)
//   a, b                 IEEE-754 single-precision operands
//   out_valid/out_ready  result handshake
//   exp_big              biased exponent of the larger operand (denormal -> 1)
//   mant_big             larger mantissa including the hidden bit
//   mant_small           aligned smaller mantissa {hidden, frac, G, R, S}
//   sign_big/sign_small  operand signs
//   swapped              1 when B is the larger operand
//   special              either operand has exponent 255 (Inf/NaN)
module exponent_align #(
    parameter int unsigned MAX_SHIFT = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_big,
    output logic [23:0] mant_big,
    output logic [26:0] mant_small,
    output logic        sign_big,
    output logic        sign_small,
    output logic        swapped,
    output logic        special
);

    localparam int unsigned CW = $clog2(MAX_SHIFT + 1);
    localparam logic [7:0]    MAX8 = 8'(MAX_SHIFT);
    localparam logic [CW-1:0] MAXC = CW'(MAX_SHIFT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Unpacked view of the incoming operand pair
    logic [31:0]   big_op, small_op;
    logic          swap_n;
    logic [7:0]    eexp_big_n, eexp_small_n, diff_n;
    logic          special_n, small_zero_n;
    logic [CW-1:0] n_shift;

    always_comb begin
        swap_n       = '0;
        big_op       = a;
        small_op     = b;
        eexp_big_n   = '0;
        eexp_small_n = '0;
        diff_n       = '0;
        special_n    = '0;
        small_zero_n = '0;
        n_shift      = '0;

        // Magnitude order is the order of {exp, frac} as an unsigned integer
        swap_n = (a[30:0] < b[30:0]);
        if (swap_n) begin
            big_op   = b;
            small_op = a;
        end

        eexp_big_n   = (big_op[30:23]   == 8'd0) ? 8'd1 : big_op[30:23];
        eexp_small_n = (small_op[30:23] == 8'd0) ? 8'd1 : small_op[30:23];
        diff_n       = eexp_big_n - eexp_small_n;

        special_n    = (&a[30:23]) | (&b[30:23]);
        small_zero_n = (small_op[30:0] == 31'd0);

        if (special_n || small_zero_n)
            n_shift = '0;
        else if (diff_n > MAX8)
            n_shift = MAXC;
        else
            n_shift = diff_n[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            exp_big    <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            swapped    <= 1'b0;
            special    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        exp_big    <= eexp_big_n;
                        mant_big   <= {|big_op[30:23], big_op[22:0]};
                        mant_small <= {|small_op[30:23], small_op[22:0], 3'b000};
                        sign_big   <= big_op[31];
                        sign_small <= small_op[31];
                        swapped    <= swap_n;
                        special    <= special_n;
                        cnt        <= n_shift;
                        in_ready   <= 1'b0;
                        if (n_shift != '0) begin
                            state <= SHIFT;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // Bits leaving position 1 are OR-ed into the sticky bit
                    mant_small <= {1'b0, mant_small[26:2], mant_small[1] | mant_small[0]};
                    cnt        <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exponent_align.sv
// tb_exponent_align: directed-vector bench for exponent_align.
// Each step drives one operand pair, counts clock edges until out_valid and
// compares the registered outputs against hand-computed values.
module tb_exponent_align;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_big;
    logic [23:0] mant_big;
    logic [26:0] mant_small;
    logic        sign_big;
    logic        sign_small;
    logic        swapped;
    logic        special;

    int unsigned total;
    int unsigned bad;
    int unsigned edges;

    exponent_align #(.MAX_SHIFT(27)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exp_big    (exp_big),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .swapped    (swapped),
        .special    (special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Present one operand pair for a single accepting edge, then count edges
    // (accepting edge included) until out_valid, bounded.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, output int unsigned n);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   32'(in_ready),   32'h1);
        chk("rst_out_valid",  32'(out_valid),  32'h0);
        chk("rst_mant_small", 32'(mant_small), 32'h0);
        chk("rst_exp_big",    32'(exp_big),    32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1.0 vs 0.5: diff 1
        issue(32'h3F800000, 32'h3F000000, edges);
        chk("c1_latency",    edges,            32'd2);
        chk("c1_swapped",    32'(swapped),     32'h0);
        chk("c1_exp_big",    32'(exp_big),     32'h7F);
        chk("c1_mant_big",   32'(mant_big),    32'h800000);
        chk("c1_mant_small", 32'(mant_small),  32'h2000000);
        chk("c1_in_ready",   32'(in_ready),    32'h0);
        release_result();
        chk("c1_idle_ready", 32'(in_ready),    32'h1);
        chk("c1_idle_valid", 32'(out_valid),   32'h0);

        // Same pair, operands exchanged
        issue(32'h3F000000, 32'h3F800000, edges);
        chk("c2_latency",    edges,            32'd2);
        chk("c2_swapped",    32'(swapped),     32'h1);
        chk("c2_exp_big",    32'(exp_big),     32'h7F);
        chk("c2_mant_big",   32'(mant_big),    32'h800000);
        chk("c2_mant_small", 32'(mant_small),  32'h2000000);
        chk("c2_signs",      32'({sign_big, sign_small}), 32'h0);
        release_result();

        // diff 24: hidden bit lands in G
        issue(32'h4B800000, 32'h3F800000, edges);
        chk("c3_latency",    edges,            32'd25);
        chk("c3_exp_big",    32'(exp_big),     32'h97);
        chk("c3_mant_small", 32'(mant_small),  32'h0000004);
        release_result();

        // diff 32: saturates at 27 shifts, only sticky survives
        issue(32'h4F800000, 32'h3F800001, edges);
        chk("c4_latency",    edges,            32'd28);
        chk("c4_exp_big",    32'(exp_big),     32'h9F);
        chk("c4_mant_small", 32'(mant_small),  32'h0000001);
        release_result();

        // Zero small operand: no shift, then backpressure with ignored input
        issue(32'h40400000, 32'h00000000, edges);
        chk("c5_latency",    edges,            32'd1);
        chk("c5_exp_big",    32'(exp_big),     32'h80);
        chk("c5_mant_big",   32'(mant_big),    32'hC00000);
        chk("c5_mant_small", 32'(mant_small),  32'h0);
        a        = 32'h3F800000;
        b        = 32'h3F000000;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("c5_hold_valid", 32'(out_valid),   32'h1);
        chk("c5_hold_ready", 32'(in_ready),    32'h0);
        chk("c5_hold_exp",   32'(exp_big),     32'h80);
        chk("c5_hold_mant",  32'(mant_big),    32'hC00000);
        chk("c5_hold_small", 32'(mant_small),  32'h0);
        release_result();
        chk("c5_idle_ready", 32'(in_ready),    32'h1);
        chk("c5_idle_valid", 32'(out_valid),   32'h0);

        // Equal magnitude, opposite signs: no swap, no shift
        issue(32'h3F800000, 32'hBF800000, edges);
        chk("c6_latency",    edges,            32'd1);
        chk("c6_swapped",    32'(swapped),     32'h0);
        chk("c6_signs",      32'({sign_big, sign_small}), 32'h1);
        chk("c6_mant_small", 32'(mant_small),  32'h4000000);
        release_result();

        // Inf operand: passed through unshifted
        issue(32'h7F800000, 32'h3F800000, edges);
        chk("c7_latency",    edges,            32'd1);
        chk("c7_special",    32'(special),     32'h1);
        chk("c7_exp_big",    32'(exp_big),     32'hFF);
        chk("c7_mant_small", 32'(mant_small),  32'h4000000);
        release_result();

        // Denormal small operand: effective exponent 1, no hidden bit
        issue(32'h00800000, 32'h00400000, edges);
        chk("c8_latency",    edges,            32'd1);
        chk("c8_exp_big",    32'(exp_big),     32'h01);
        chk("c8_mant_small", 32'(mant_small),  32'h2000000);
        release_result();

        // Reset in the middle of a long shift
        a        = 32'h4B800000;
        b        = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(in_ready),    32'h1);
        chk("rst_mid_valid", 32'(out_valid),   32'h0);
        chk("rst_mid_small", 32'(mant_small),  32'h0);
        chk("rst_mid_exp",   32'(exp_big),     32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h3F800000, 32'h3F000000, edges);
        chk("c9_latency",    edges,            32'd2);
        chk("c9_exp_big",    32'(exp_big),     32'h7F);
        chk("c9_mant_small", 32'(mant_small),  32'h2000000);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exponent_align.md
Name: exponent_align

Overview:
- Input-side counterpart to the post-normalisation exponent adjust in the FP adder datapath.
- Accepts two IEEE-754 single-precision operands and unpacks them.
- Selects the larger-magnitude operand and computes the exponent difference.
- Right-aligns the smaller mantissa serially, one bit per cycle, keeping guard/round/sticky bits; hands the aligned pair to the mantissa adder over a valid/ready handshake.

Parameters:
- MAX_SHIFT, 27, saturation limit on shift count (mantissa width 24 + 3 GRS bits).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a  input  32  operand A, IEEE-754 single.
- b  input  32  operand B, IEEE-754 single.
- out_valid  output  1  aligned result valid.
- out_ready  input  1  downstream accepts result.
- exp_big  output  8  biased exponent of larger operand (denormal reported as 1).
- mant_big  output  24  larger operand mantissa incl. hidden bit.
- mant_small  output  27  aligned smaller mantissa, {hidden, frac[22:0], G, R, S}.
- sign_big  output  1  sign of larger operand.
- sign_small  output  1  sign of smaller operand.
- swapped  output  1  1 = B was larger (B is big, A is small).
- special  output  1  either operand has exponent 255 (Inf/NaN).

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except in_ready=1; shift counter 0.
- Unpack: hidden = (exp != 0); effective exponent = (exp == 0) ? 1 : exp.
- Magnitude compare on {exp, frac}. A strictly smaller → swapped=1; equal magnitudes → swapped=0.
- diff = eexp_big − eexp_small, 8-bit unsigned, never negative.
- N = min(diff, MAX_SHIFT). N is forced to 0 if the small operand is zero (exp=0, frac=0) or if special=1.
- mant_small is loaded as {hidden_s, frac_s, 3'b000}.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: latch the unpacked fields and load the counter with N.
  - Next state is SHIFT if N>0, else DONE.
- State SHIFT:
  - in_ready=0.
  - Each cycle: mant_small ← {1'b0, mant_small[26:2], mant_small[1] | mant_small[0]}, i.e. sticky accumulates; counter decrements.
  - When the counter reaches 1, the shift executes and the next state is DONE.
- State DONE:
  - out_valid=1; outputs held stable.
  - On out_ready: next state IDLE, out_valid deasserts next cycle.
  - No new operand is accepted in the same cycle as out_ready (in_ready=0 in DONE).
- Latency: out_valid rises N+1 clock edges after the accepting edge. Minimum throughput is one result per N+2 cycles.
- Saturation: diff ≥ 27 performs exactly 27 shifts. The result is 27'h1 if the small mantissa was nonzero, else 0.
- Backpressure: out_ready held low keeps DONE indefinitely with all outputs unchanged.
- in_valid while not in IDLE is ignored; operands are not sampled.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to reset values; the partial result is discarded.
- special=1: operands are passed through unpacked and unshifted. Inf/NaN resolution belongs to the downstream exception logic.

Test Plan:
- a=0x3F800000, b=0x3F000000 → after 2 edges: out_valid=1, swapped=0, exp_big=0x7F, mant_big=0x800000, mant_small=27'h2000000.
- a=0x3F000000, b=0x3F800000 → same values as above with swapped=1; sign_big=sign_small=0.
- a=0x4B800000, b=0x3F800000 (diff 24) → out_valid after 25 edges, exp_big=0x97, mant_small=27'h0000004 (G=1, R=0, S=0).
- a=0x4F800000, b=0x3F800001 (diff 32, saturated) → exactly 27 shift cycles, out_valid at edge 28, mant_small=27'h0000001 (sticky only).
- b=0x00000000, a=0x40400000 → N=0, out_valid after 1 edge, mant_small=0, exp_big=0x80; then hold out_ready=0 for 10 cycles → outputs stable, in_ready=0; pulse out_ready → IDLE, in_ready=1 next cycle.
- Start diff-24 case, assert rst_n=0 at shift cycle 10 → all outputs 0 and in_ready=1 immediately (asynchronously); release rst_n, re-issue the first case → correct result with 2-edge latency.
